// File: rtl/mult_16_pkg.sv
// Shared constants and types for the mult_16 pipelined multiplier.
package mult_16_pkg;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 2 * IN_W;
    localparam int LATENCY = 2;

    typedef logic [IN_W-1:0]  operand_t;
    typedef logic [OUT_W-1:0] product_t;

endpackage : mult_16_pkg

// File: rtl/mult_16_csa.sv
// One row of 3:2 carry-save compressors. Three W-bit addends in, a sum
// word and a carry word out. The carry word is already shifted left by
// one, so sum + carry == x + y + z (mod 2^W).
module mult_16_csa
    import mult_16_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    // Bitwise full-adder: parity to sum, majority to the next column.
    always_comb begin
        sum   = x ^ y ^ z;
        maj   = (x & y) | (x & z) | (y & z);
        carry = {maj[W-2:0], 1'b0};
    end

endmodule : mult_16_csa

// File: rtl/mult_16.sv
// Two-stage pipelined 16x16 multiplier with a 32-bit product.
//   Stage 1: partial products, carry-save reduction tree, register sum/carry.
//   Stage 2: carry-propagate add into r.
// Build option: define MULT_16_SIGNED_EN to add the is_signed port and
// Baugh-Wooley sign correction of the partial products.
module mult_16
    import mult_16_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
`ifdef MULT_16_SIGNED_EN
    input  logic              is_signed,
`endif
    output logic [2*IN_W-1:0] r,
    output logic              out_valid
);

    localparam int OUT_W = 2 * IN_W;

    // The reduction tree below is laid out by hand for exactly 16 rows.
    if (IN_W != 16) begin : g_width_check
        $error("mult_16: only IN_W == 16 is supported");
    end

    // Sign-correction enable; constant zero in the unsigned build so the
    // correction logic disappears entirely.
`ifdef MULT_16_SIGNED_EN
    logic sign_corr;
    assign sign_corr = is_signed;
`endif

    product_t pp [16];

    // Partial-product rows: row gi is a gated by b[gi], shifted left by gi.
    // In signed mode, the row/column that involves exactly one sign bit is
    // inverted, and the constant 2^16 + 2^31 is folded into row 0 (whose
    // bits 16 and 31 are otherwise always zero, so OR equals add).
    for (genvar gi = 0; gi < 16; gi++) begin : g_pp
        logic [15:0] row_bits;
`ifdef MULT_16_SIGNED_EN
        localparam logic [15:0] CORR_MASK = (gi < 15) ? 16'h8000 : 16'h7FFF;
        assign row_bits = (a & {16{b[gi]}}) ^ (CORR_MASK & {16{sign_corr}});
        if (gi == 0) begin : g_row0
            assign pp[gi] = ({16'h0000, row_bits} << gi)
                          | {sign_corr, 14'h0000, sign_corr, 16'h0000};
        end else begin : g_rown
            assign pp[gi] = {16'h0000, row_bits} << gi;
        end
`else
        assign row_bits = a & {16{b[gi]}};
        assign pp[gi]   = {16'h0000, row_bits} << gi;
`endif
    end

    // Reduction tree: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows. Rows that
    // do not fill a full group of three pass straight to the next level.
    product_t l1 [11];
    product_t l2 [8];
    product_t l3 [6];
    product_t l4 [4];
    product_t l5 [3];
    product_t sum_comb;
    product_t carry_comb;

    for (genvar gi = 0; gi < 5; gi++) begin : g_l1
        mult_16_csa #(.W(OUT_W)) u_csa (
            .x(pp[3*gi]), .y(pp[3*gi+1]), .z(pp[3*gi+2]),
            .sum(l1[2*gi]), .carry(l1[2*gi+1])
        );
    end
    assign l1[10] = pp[15];

    for (genvar gi = 0; gi < 3; gi++) begin : g_l2
        mult_16_csa #(.W(OUT_W)) u_csa (
            .x(l1[3*gi]), .y(l1[3*gi+1]), .z(l1[3*gi+2]),
            .sum(l2[2*gi]), .carry(l2[2*gi+1])
        );
    end
    assign l2[6] = l1[9];
    assign l2[7] = l1[10];

    for (genvar gi = 0; gi < 2; gi++) begin : g_l3
        mult_16_csa #(.W(OUT_W)) u_csa (
            .x(l2[3*gi]), .y(l2[3*gi+1]), .z(l2[3*gi+2]),
            .sum(l3[2*gi]), .carry(l3[2*gi+1])
        );
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    for (genvar gi = 0; gi < 2; gi++) begin : g_l4
        mult_16_csa #(.W(OUT_W)) u_csa (
            .x(l3[3*gi]), .y(l3[3*gi+1]), .z(l3[3*gi+2]),
            .sum(l4[2*gi]), .carry(l4[2*gi+1])
        );
    end

    mult_16_csa #(.W(OUT_W)) u_csa_l5 (
        .x(l4[0]), .y(l4[1]), .z(l4[2]),
        .sum(l5[0]), .carry(l5[1])
    );
    assign l5[2] = l4[3];

    mult_16_csa #(.W(OUT_W)) u_csa_l6 (
        .x(l5[0]), .y(l5[1]), .z(l5[2]),
        .sum(sum_comb), .carry(carry_comb)
    );

    product_t s1_sum_reg;
    product_t s1_carry_reg;
    logic     s1_valid_reg;
    product_t r_reg;
    logic     out_valid_reg;

    // Stage 1: capture the carry-save pair only for valid operands so idle
    // inputs never reach the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum_reg   <= '0;
            s1_carry_reg <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sum_reg   <= sum_comb;
                s1_carry_reg <= carry_comb;
            end
        end
    end

    // Stage 2: final carry-propagate add; r holds the last product in bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                r_reg <= s1_sum_reg + s1_carry_reg;
            end
        end
    end

    assign r         = r_reg;
    assign out_valid = out_valid_reg;

endmodule : mult_16

// File: tb/tb_mult_16.sv
// Directed self-checking bench for mult_16 (signed cases when
// MULT_16_SIGNED_EN is defined).
module tb_mult_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
`ifdef MULT_16_SIGNED_EN
    logic        is_signed;
`endif
    logic [31:0] r;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    mult_16 #(.IN_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .a(a),
        .b(b),
`ifdef MULT_16_SIGNED_EN
        .is_signed(is_signed),
`endif
        .r(r),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] x, input logic [15:0] y, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
`ifdef MULT_16_SIGNED_EN
        is_signed = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    // One isolated pair: present it, idle, then check two edges later.
    task automatic run_pair(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic [31:0] exp);
        @(negedge clk);
        set_in(1'b1, x, y, s);
        @(negedge clk);
        set_in(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        @(negedge clk);
        check({tag, " valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, " r"}, r, exp);
        $display("txn %s: a=0x%04h b=0x%04h r=0x%08h", tag, x, y, r);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        rst_n = 1'b1;
        set_in(1'b1, 16'h1234, 16'h5678, 1'b0);
        #1 rst_n = 1'b0;

        // Reset held with valid input: nothing may come out.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset r", r, 32'h0);
            check("reset valid", {31'b0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_in(1'b0, 16'h0, 16'h0, 1'b0);
        check("post-reset edge1 valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("post-reset edge2 valid", {31'b0, out_valid}, 32'd1);
        check("post-reset edge2 r", r, 32'h06260060);
        $display("txn reset-release: a=0x1234 b=0x5678 r=0x%08h", r);

        // Unsigned corners.
        run_pair("max*max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        run_pair("zero", 16'h0000, 16'hABCD, 1'b0, 32'h00000000);
        run_pair("one", 16'h0001, 16'hBEEF, 1'b0, 32'h0000BEEF);
        run_pair("msb*2", 16'h8000, 16'h0002, 1'b0, 32'h00010000);

        // Streaming: back-to-back random pairs, checked two cycles later.
        for (int i = 0; i < 1002; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            logic [31:0] e;
            @(negedge clk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                check("stream valid", {31'b0, out_valid}, 32'd1);
                check("stream r", r, e);
                $display("txn stream %0d: r=0x%08h exp=0x%08h", i - 2, r, e);
            end
            if (i < 1000) begin
                x = 16'($urandom);
                y = 16'($urandom);
                set_in(1'b1, x, y, 1'b0);
                exp_q.push_back({16'h0, x} * {16'h0, y});
            end else begin
                set_in(1'b0, 16'h0, 16'h0, 1'b0);
            end
        end

        // Bubbles: in_valid 1,0,0,1 with junk operands in the gaps.
        @(negedge clk); set_in(1'b1, 16'd3, 16'd5, 1'b0);
        @(negedge clk); set_in(1'b0, 16'hDEAD, 16'hBEEF, 1'b0);
        @(negedge clk); set_in(1'b0, 16'hFFFF, 16'h1357, 1'b0);
        check("bubble out0 valid", {31'b0, out_valid}, 32'd1);
        check("bubble out0 r", r, 32'd15);
        $display("txn bubble 3*5: r=%0d", r);
        @(negedge clk); set_in(1'b1, 16'd7, 16'd9, 1'b0);
        check("bubble gap1 valid", {31'b0, out_valid}, 32'd0);
        check("bubble gap1 r hold", r, 32'd15);
        @(negedge clk); set_in(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        check("bubble gap2 valid", {31'b0, out_valid}, 32'd0);
        check("bubble gap2 r hold", r, 32'd15);
        @(negedge clk);
        check("bubble out3 valid", {31'b0, out_valid}, 32'd1);
        check("bubble out3 r", r, 32'd63);
        $display("txn bubble 7*9: r=%0d", r);

        // Mid-stream reset with two products in flight.
        @(negedge clk); set_in(1'b1, 16'h0102, 16'h0304, 1'b0);
        @(negedge clk); set_in(1'b1, 16'h0506, 16'h0708, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midreset r", r, 32'h0);
        check("midreset valid", {31'b0, out_valid}, 32'd0);
        set_in(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset drain valid", {31'b0, out_valid}, 32'd0);
            check("midreset drain r", r, 32'h0);
        end
        $display("txn mid-stream reset: in-flight products discarded");

`ifdef MULT_16_SIGNED_EN
        run_pair("s -1*-1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        run_pair("s min*min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        run_pair("s min*1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        run_pair("s -3*5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
        run_pair("u max*max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mult_16
